// File: rtl/cluster_ce_seq_if.sv
// Request/response bundle between the kd-tree traversal controller and the
// cluster compute element: valid/ready on both the request and result sides.
interface cluster_ce_seq_if #(
    parameter int DIM    = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
);
    localparam int ACC_W = DATA_W + CNT_W;
    localparam int AX_W  = (DIM > 1) ? $clog2(DIM) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic                  op;
    logic                  returned;
    logic [AX_W-1:0]       axis;
    logic [DIM*DATA_W-1:0] point;
    logic [DIM*ACC_W-1:0]  cand_acc;
    logic [CNT_W-1:0]      cand_cnt;
    logic [DIM*ACC_W-1:0]  best_acc;
    logic [CNT_W-1:0]      best_cnt;

    logic                  out_valid;
    logic                  out_ready;
    logic                  first_dir;
    logic                  change_best;
    logic                  other_branch;
    logic [DIM*ACC_W-1:0]  res_acc;
    logic [CNT_W-1:0]      res_cnt;
    logic                  err;

    modport slave (
        input  in_valid, op, returned, axis, point, cand_acc, cand_cnt,
               best_acc, best_cnt, out_ready,
        output in_ready, out_valid, first_dir, change_best, other_branch,
               res_acc, res_cnt, err
    );

    modport master (
        output in_valid, op, returned, axis, point, cand_acc, cand_cnt,
               best_acc, best_cnt, out_ready,
        input  in_ready, out_valid, first_dir, change_best, other_branch,
               res_acc, res_cnt, err
    );
endinterface

// File: rtl/cluster_ce_seq.sv
// Sequential kd-tree cluster compute element: NEAREST decision (one dimension
// per cycle, division-free cross-multiplied compare) or ACCUM point fold.
module cluster_ce_seq #(
    parameter int DIM    = 3,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    cluster_ce_seq_if.slave  bus
);
    localparam int ACC_W = DATA_W + CNT_W;
    localparam int AX_W  = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SD_W  = 2*ACC_W + $clog2(DIM) + 1;
    localparam int L_W   = SD_W + 2*CNT_W;
    localparam logic [AX_W-1:0]  K_LAST  = AX_W'(DIM - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_DIST, S_SCALE, S_ACC, S_DONE} state_t;

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_returned;
    logic [AX_W-1:0]       r_axis;
    logic                  r_ax_bad;
    logic [DIM*DATA_W-1:0] r_point;
    logic [DIM*ACC_W-1:0]  r_cand_acc;
    logic [CNT_W-1:0]      r_cand_cnt;
    logic [DIM*ACC_W-1:0]  r_best_acc;
    logic [CNT_W-1:0]      r_best_cnt;
    logic [AX_W-1:0]       r_k;
    logic [SD_W-1:0]       r_dc;
    logic [SD_W-1:0]       r_db;
    logic [ACC_W-1:0]      r_eax_abs;
    logic                  r_fd;

    logic                  r_out_valid;
    logic                  r_first_dir;
    logic                  r_change_best;
    logic                  r_other_branch;
    logic [DIM*ACC_W-1:0]  r_res_acc;
    logic [CNT_W-1:0]      r_res_cnt;
    logic                  r_err;

    function automatic logic [2*ACC_W-1:0] sq(input logic [ACC_W-1:0] v);
        return (2*ACC_W)'(v) * (2*ACC_W)'(v);
    endfunction

    // Per-dimension error terms; |e| always fits ACC_W bits, so squares stay unsigned.
    logic [DATA_W-1:0]  w_pk;
    logic [ACC_W-1:0]   w_cak, w_bak, w_pc, w_pb;
    logic [ACC_W:0]     w_ec, w_eb, w_ec_neg, w_eb_neg;
    logic [ACC_W-1:0]   w_abs_c, w_abs_b;
    logic [2*ACC_W-1:0] w_sq_c, w_sq_b;

    assign w_pk     = r_point[int'(r_k)*DATA_W +: DATA_W];
    assign w_cak    = r_cand_acc[int'(r_k)*ACC_W +: ACC_W];
    assign w_bak    = r_best_acc[int'(r_k)*ACC_W +: ACC_W];
    assign w_pc     = ACC_W'(w_pk) * ACC_W'(r_cand_cnt);
    assign w_pb     = ACC_W'(w_pk) * ACC_W'(r_best_cnt);
    assign w_ec     = {1'b0, w_pc} - {1'b0, w_cak};
    assign w_eb     = {1'b0, w_pb} - {1'b0, w_bak};
    assign w_ec_neg = -w_ec;
    assign w_eb_neg = -w_eb;
    assign w_abs_c  = w_ec[ACC_W] ? w_ec_neg[ACC_W-1:0] : w_ec[ACC_W-1:0];
    assign w_abs_b  = w_eb[ACC_W] ? w_eb_neg[ACC_W-1:0] : w_eb[ACC_W-1:0];
    assign w_sq_c   = sq(w_abs_c);
    assign w_sq_b   = sq(w_abs_b);

    // Distances compared as Dc/cc^2 < Db/bc^2 without dividing.
    logic [2*CNT_W-1:0] w_bc2, w_cc2;
    logic [L_W-1:0]     w_lc, w_lb, w_lax;
    logic               w_change, w_other;

    assign w_bc2 = (2*CNT_W)'(r_best_cnt) * (2*CNT_W)'(r_best_cnt);
    assign w_cc2 = (2*CNT_W)'(r_cand_cnt) * (2*CNT_W)'(r_cand_cnt);
    assign w_lc  = L_W'(r_dc) * L_W'(w_bc2);
    assign w_lb  = L_W'(r_db) * L_W'(w_cc2);
    assign w_lax = L_W'(sq(r_eax_abs)) * L_W'(w_bc2);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_change = 1'b0;
        w_other  = 1'b0;
        if (r_cand_cnt == '0)      w_change = 1'b0;
        else if (r_best_cnt == '0) w_change = 1'b1;
        else                       w_change = (w_lc < w_lb);
        if (r_ax_bad)              w_other = 1'b1;
        else if (!r_returned)      w_other = 1'b0;
        else if (r_best_cnt == '0) w_other = 1'b1;
        else                       w_other = (w_lax < w_lb);
    end

    logic [DIM*ACC_W-1:0] w_acc_sum;

    always_comb begin
        w_acc_sum = r_cand_acc;
        for (int k = 0; k < DIM; k++) begin
            w_acc_sum[k*ACC_W +: ACC_W] = r_cand_acc[k*ACC_W +: ACC_W]
                                        + ACC_W'(r_point[k*DATA_W +: DATA_W]);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_in_ready     <= 1'b1;
            r_returned     <= 1'b0;
            r_axis         <= '0;
            r_ax_bad       <= 1'b0;
            r_point        <= '0;
            r_cand_acc     <= '0;
            r_cand_cnt     <= '0;
            r_best_acc     <= '0;
            r_best_cnt     <= '0;
            r_k            <= '0;
            r_dc           <= '0;
            r_db           <= '0;
            r_eax_abs      <= '0;
            r_fd           <= 1'b0;
            r_out_valid    <= 1'b0;
            r_first_dir    <= 1'b0;
            r_change_best  <= 1'b0;
            r_other_branch <= 1'b0;
            r_res_acc      <= '0;
            r_res_cnt      <= '0;
            r_err          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        r_returned <= bus.returned;
                        r_axis     <= bus.axis;
                        r_ax_bad   <= (int'(bus.axis) >= DIM);
                        r_point    <= bus.point;
                        r_cand_acc <= bus.cand_acc;
                        r_cand_cnt <= bus.cand_cnt;
                        r_best_acc <= bus.best_acc;
                        r_best_cnt <= bus.best_cnt;
                        r_k        <= '0;
                        r_dc       <= '0;
                        r_db       <= '0;
                        r_eax_abs  <= '0;
                        r_fd       <= 1'b0;
                        r_state    <= bus.op ? S_ACC : S_DIST;
                    end
                end
                S_DIST: begin
                    r_dc <= r_dc + SD_W'(w_sq_c);
                    r_db <= r_db + SD_W'(w_sq_b);
                    if (r_k == r_axis) begin
                        r_eax_abs <= w_abs_c;
                        r_fd      <= w_ec[ACC_W];
                    end
                    if (r_k == K_LAST) r_state <= S_SCALE;
                    else               r_k     <= r_k + 1'b1;
                end
                S_SCALE: begin
                    r_first_dir    <= r_fd & ~r_ax_bad;
                    r_change_best  <= w_change;
                    r_other_branch <= w_other;
                    r_res_acc      <= w_change ? r_cand_acc : r_best_acc;
                    r_res_cnt      <= w_change ? r_cand_cnt : r_best_cnt;
                    r_err          <= r_ax_bad;
                    r_out_valid    <= 1'b1;
                    r_state        <= S_DONE;
                end
                S_ACC: begin
                    r_first_dir    <= 1'b0;
                    r_change_best  <= 1'b0;
                    r_other_branch <= 1'b0;
                    if (r_cand_cnt == CNT_MAX) begin
                        r_res_acc <= r_cand_acc;
                        r_res_cnt <= r_cand_cnt;
                        r_err     <= 1'b1;
                    end else begin
                        r_res_acc <= w_acc_sum;
                        r_res_cnt <= r_cand_cnt + 1'b1;
                        r_err     <= 1'b0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.first_dir    = r_first_dir;
    assign bus.change_best  = r_change_best;
    assign bus.other_branch = r_other_branch;
    assign bus.res_acc      = r_res_acc;
    assign bus.res_cnt      = r_res_cnt;
    assign bus.err          = r_err;
endmodule

// File: tb/tb_cluster_ce_seq.sv
// Randomized scoreboard bench for cluster_ce_seq against an arithmetic reference model.
module tb_cluster_ce_seq;
    localparam int DIM     = 3;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 7;
    localparam int ACC_W   = DATA_W + CNT_W;
    localparam int CNT_MAX = 127;

    typedef logic [DIM*DATA_W-1:0] pvec_t;
    typedef logic [DIM*ACC_W-1:0]  avec_t;
    typedef logic [55:0]           flat_t;   // {fd, cb, ob, err, res_acc, res_cnt}

    typedef struct {
        string name;
        flat_t flat;
        int    lat;
        int    acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cluster_ce_seq_if #(.DIM(DIM), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus();

    cluster_ce_seq #(.DIM(DIM), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   force_hold = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic pvec_t P(input int a, input int b, input int c);
        return {8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic avec_t A(input int a, input int b, input int c);
        return {15'(c), 15'(b), 15'(a)};
    endfunction

    // Reference: squared distances to the centres acc/cnt, scaled by cnt^2 on both sides.
    function automatic flat_t model(input bit op, input bit ret, input int ax, input pvec_t p,
                                    input avec_t ca, input int cc, input avec_t ba, input int bc);
        avec_t  acc;
        int     cnt;
        bit     fd, cb, ob, er;
        longint dc, db, eax, pk, cak, bak, ec, eb;
        fd = 0; cb = 0; ob = 0; er = 0; dc = 0; db = 0; eax = 0;
        acc = '0; cnt = 0;
        if (op) begin
            if (cc == CNT_MAX) begin
                acc = ca; cnt = cc; er = 1;
            end else begin
                for (int k = 0; k < DIM; k++)
                    acc[k*ACC_W +: ACC_W] = ca[k*ACC_W +: ACC_W] + 15'(p[k*DATA_W +: DATA_W]);
                cnt = cc + 1;
            end
        end else begin
            for (int k = 0; k < DIM; k++) begin
                pk  = p[k*DATA_W +: DATA_W];
                cak = ca[k*ACC_W +: ACC_W];
                bak = ba[k*ACC_W +: ACC_W];
                ec  = pk*cc - cak;
                eb  = pk*bc - bak;
                dc += ec*ec;
                db += eb*eb;
                if (k == ax) begin eax = ec; fd = (ec < 0); end
            end
            if (cc == 0)      cb = 0;
            else if (bc == 0) cb = 1;
            else              cb = (dc*bc*bc < db*cc*cc);
            if (ax >= DIM) begin er = 1; fd = 0; ob = 1; end
            else if (!ret)    ob = 0;
            else if (bc == 0) ob = 1;
            else              ob = (eax*eax*bc*bc < db*cc*cc);
            acc = cb ? ca : ba;
            cnt = cb ? cc : bc;
        end
        return {fd, cb, ob, er, acc, 7'(cnt)};
    endfunction

    task automatic issue(input string name, input bit op, input bit ret, input int ax,
                         input pvec_t p, input avec_t ca, input int cc, input avec_t ba,
                         input int bc, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.returned = ret;
        bus.axis     = 2'(ax);
        bus.point    = p;
        bus.cand_acc = ca;
        bus.cand_cnt = 7'(cc);
        bus.best_acc = ba;
        bus.best_cnt = 7'(bc);
        n = 0;
        while (!bus.in_ready && n < 300) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin
            fail({name, "_accept_timeout"});
            bus.in_valid = 1'b0;
            return;
        end
        e.name    = name;
        e.flat    = model(op, ret, ax, p, ca, cc, ba, bc);
        e.lat     = op ? 2 : DIM + 2;
        e.acc_cyc = cyc + 1;
        if (push) q.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.point    = pvec_t'({$urandom, $urandom});
        bus.cand_acc = avec_t'({$urandom, $urandom});
        bus.best_acc = avec_t'({$urandom, $urandom});
        bus.cand_cnt = 7'($urandom);
        bus.best_cnt = 7'($urandom);
        bus.axis     = 2'($urandom);
        bus.op       = 1'($urandom);
        bus.returned = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || !bus.in_ready) && n < 300) begin @(negedge clk); n++; end
        if (q.size() != 0 || !bus.in_ready) begin
            fail("drain_timeout");
            q.delete();
        end
    endtask

    // Monitor: pops the scoreboard on the first cycle a result is presented,
    // then throttles out_ready and verifies the result holds until consumed.
    initial begin
        flat_t got, snap;
        exp_t  e;
        bit    holding = 1'b0;
        bit    stable_ok = 1'b1;
        int    hold_left = 0;
        snap = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            got = {bus.first_dir, bus.change_best, bus.other_branch, bus.err, bus.res_acc, bus.res_cnt};
            if (rst) begin
                holding = 1'b0;
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                if (!holding) begin
                    holding   = 1'b1;
                    stable_ok = !bus.in_ready;
                    snap      = got;
                    if (q.size() == 0) fail("unexpected_output");
                    else begin
                        e = q.pop_front();
                        check(e.name, 128'(got), 128'(e.flat));
                        check({e.name, "_latency"}, 128'(cyc - e.acc_cyc + 1), 128'(e.lat));
                    end
                    hold_left = force_hold ? 4 : int'($urandom_range(2, 0));
                end else if (got !== snap || bus.in_ready) begin
                    stable_ok = 1'b0;
                end
                bus.out_ready = (hold_left == 0);
                if (hold_left > 0) hold_left--;
            end else begin
                if (holding) check("hold_stable", 128'(stable_ok), 128'(1));
                holding = 1'b0;
                bus.out_ready = 1'b0;
            end
        end
    end

    initial begin
        avec_t ca, ba;
        pvec_t p;
        int    cc, bc, r;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 1'b0;
        bus.returned = 1'b0;
        bus.axis     = '0;
        bus.point    = '0;
        bus.cand_acc = '0;
        bus.cand_cnt = '0;
        bus.best_acc = '0;
        bus.best_cnt = '0;
        repeat (3) @(negedge clk);
        check("reset_state",
              128'({bus.in_ready, bus.out_valid, bus.first_dir, bus.change_best, bus.other_branch,
                    bus.err, bus.res_acc, bus.res_cnt}),
              128'({1'b1, 57'd0}));
        rst = 1'b0;

        issue("t1_nearest", 0, 0, 0, P(10,20,30), A(20,40,60), 2, A(0,0,0), 1, 1);
        issue("t2_dir_left", 0, 0, 0, P(5,20,30), A(20,40,60), 2, A(0,0,0), 1, 1);
        issue("t2_dir_tie", 0, 0, 0, P(10,20,30), A(20,40,60), 2, A(0,0,0), 1, 1);
        issue("t3_accum", 1, 0, 0, P(7,8,9), A(100,0,0), 4, A(0,0,0), 0, 1);
        issue("t3_accum_sat", 1, 0, 0, P(7,8,9), A(100,0,0), 127, A(0,0,0), 0, 1);
        issue("t4_no_best", 0, 0, 1, P(1,2,3), A(9,9,9), 3, A(0,0,0), 0, 1);
        issue("t4_empty_cand", 0, 0, 1, P(1,2,3), A(0,0,0), 0, A(5,5,5), 2, 1);
        issue("t4_ret_no_best", 0, 1, 2, P(1,2,3), A(9,9,9), 3, A(0,0,0), 0, 1);
        issue("t4_bad_axis", 0, 0, 3, P(10,20,30), A(20,40,60), 2, A(0,0,0), 1, 1);
        issue("t5_backtrack_near", 0, 1, 0, P(10,20,30), A(24,40,60), 2, A(11,20,30), 1, 1);
        issue("t5_backtrack_far", 0, 1, 0, P(10,20,30), A(24,40,60), 2, A(13,20,30), 1, 1);
        drain();

        force_hold = 1'b1;
        issue("t6_hold", 0, 1, 2, P(50,60,70), A(90,100,150), 2, A(40,60,80), 1, 1);
        drain();
        force_hold = 1'b0;

        issue("t6_abort", 0, 0, 0, P(10,20,30), A(20,40,60), 2, A(0,0,0), 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check("abort_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);
        rst = 1'b0;
        issue("t6_after_abort", 0, 0, 0, P(10,20,30), A(20,40,60), 2, A(0,0,0), 1, 1);
        drain();

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(9, 0));
            cc = (r == 0) ? 0 : (r == 1) ? CNT_MAX : int'($urandom_range(126, 1));
            r = int'($urandom_range(9, 0));
            bc = (r == 0) ? 0 : int'($urandom_range(127, 1));
            p = pvec_t'({$urandom, $urandom});
            for (int k = 0; k < DIM; k++) begin
                ca[k*ACC_W +: ACC_W] = 15'($urandom_range((cc == 0) ? 60 : 255*cc, 0));
                ba[k*ACC_W +: ACC_W] = 15'($urandom_range((bc == 0) ? 60 : 255*bc, 0));
            end
            if ($urandom_range(7, 0) == 0) begin ba = ca; bc = cc; end
            issue($sformatf("rand_%0d", i), ($urandom_range(3, 0) == 0), 1'($urandom),
                  int'($urandom_range(3, 0)), p, ca, cc, ba, bc, 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
